// File: rtl/conv_pkg.sv
// conv_pkg: scheduler state type plus elaboration-time geometry helpers
// shared by the convolution band scheduler and its window address generator.
package conv_pkg;
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, TILE_WAIT, DONE} sched_state_t;

    function automatic int OUT_SIZE(input int size, input int ker);
        return size - ker + 1;
    endfunction

    function automatic int band_start(input int b, input int out, input int tiles);
        return (b * out) / tiles;
    endfunction

    // Width of an index into n items, never narrower than one bit
    function automatic int wbits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_SIZE   = 256;
    localparam int DEF_KER    = 3;
    localparam int DEF_IMG_AW = wbits(DEF_SIZE * DEF_SIZE);
    localparam int DEF_KER_AW = wbits(DEF_KER * DEF_KER);
    localparam int DEF_OUT_W  = wbits(OUT_SIZE(DEF_SIZE, DEF_KER));
endpackage

// File: rtl/conv_win_addr_gen.sv
// conv_win_addr_gen: walks kernel taps and output pixels, producing image and
// kernel read addresses incrementally (adders only) plus last-tap/last-pixel flags.
module conv_win_addr_gen
    import conv_pkg::*;
#(
    parameter int SIZE = 256,
    parameter int SIZEKer = 3,
    localparam int OUT = OUT_SIZE(SIZE, SIZEKer),
    localparam int AW = wbits(SIZE * SIZE),
    localparam int KW = wbits(SIZEKer * SIZEKer),
    localparam int OW = wbits(OUT),
    localparam int TW = wbits(SIZEKer)
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          clr,
    input  logic          en,
    input  logic [OW-1:0] last_row,
    output logic [AW-1:0] img_addr,
    output logic [KW-1:0] ker_addr,
    output logic [OW-1:0] row,
    output logic [OW-1:0] col,
    output logic          tap0,
    output logic          last_tap,
    output logic          last_pix
);
    logic [TW-1:0] ki, kj;
    logic [AW-1:0] base;
    logic kj_end, ki_end, col_end, last_frame;

    assign kj_end     = kj == TW'(SIZEKer - 1);
    assign ki_end     = ki == TW'(SIZEKer - 1);
    assign col_end    = col == OW'(OUT - 1);
    assign tap0       = ki == '0 && kj == '0;
    assign last_tap   = ki_end && kj_end;
    assign last_pix   = last_tap && col_end && row == last_row;
    assign last_frame = last_tap && col_end && row == OW'(OUT - 1);

    // The frame's last pixel wraps to zero so no counter ever leaves the image
    always_ff @(posedge clock or posedge nreset)
        if (nreset || clr || (en && last_frame)) begin
            ki <= '0;
            kj <= '0;
            row <= '0;
            col <= '0;
            base <= '0;
            img_addr <= '0;
            ker_addr <= '0;
        end else if (en) begin
            if (!kj_end) begin
                kj <= kj + 1'b1;
                img_addr <= img_addr + 1'b1;
                ker_addr <= ker_addr + 1'b1;
            end else if (!ki_end) begin
                kj <= '0;
                ki <= ki + 1'b1;
                img_addr <= img_addr + AW'(OUT);
                ker_addr <= ker_addr + 1'b1;
            end else begin
                kj <= '0;
                ki <= '0;
                ker_addr <= '0;
                if (!col_end) begin
                    col <= col + 1'b1;
                    base <= base + 1'b1;
                    img_addr <= base + 1'b1;
                end else begin
                    col <= '0;
                    row <= row + 1'b1;
                    base <= base + AW'(SIZEKer);
                    img_addr <= base + AW'(SIZEKer);
                end
            end
        end
endmodule

// File: rtl/conv_band_scheduler.sv
// conv_band_scheduler: frame/band FSM for the 2-D convolution datapath; issues
// one tap per cycle, pipelines MAC/write strobes and handshakes each row band.
module conv_band_scheduler
    import conv_pkg::*;
#(
    parameter int SIZE = 256,
    parameter int SIZEKer = 3,
    parameter int WIDTH_BIT = 16,
    parameter int TOTSUBIMAGEM = 16,
    localparam int OUT = OUT_SIZE(SIZE, SIZEKer),
    localparam int AW = wbits(SIZE * SIZE),
    localparam int KW = wbits(SIZEKer * SIZEKer),
    localparam int OW = wbits(OUT),
    localparam int TIW = $clog2(TOTSUBIMAGEM) + 1
) (
    input  logic           clock,
    input  logic           nreset,
    input  logic           start,
    input  logic           abort,
    input  logic           tile_ack,
    output logic           busy,
    output logic           done,
    output logic           img_rd_en,
    output logic [AW-1:0]  img_rd_addr,
    output logic [KW-1:0]  ker_rd_addr,
    output logic           mac_en,
    output logic           mac_clr,
    output logic           wr_en,
    output logic [OW-1:0]  out_row,
    output logic [OW-1:0]  out_col,
    output logic           tile_done,
    output logic [TIW-1:0] tile_idx
);
    if (TOTSUBIMAGEM < 1 || TOTSUBIMAGEM > OUT || WIDTH_BIT < 1) begin : g_bad_cfg
        $error("conv_band_scheduler: TOTSUBIMAGEM must lie in 1..SIZE-SIZEKer+1");
    end

    sched_state_t state, nxt;
    logic drain_cnt, last_band, accept, ack_now;
    logic tap0, last_tap, last_pix, l1;
    logic [OW-1:0] row, col, row1, col1, last_row;
    logic [OW-1:0] band_last [TOTSUBIMAGEM];

    for (genvar g = 0; g < TOTSUBIMAGEM; g++) begin : g_band
        assign band_last[g] = OW'(band_start(g + 1, OUT, TOTSUBIMAGEM) - 1);
    end

    always_comb begin
        last_row = band_last[0];
        for (int i = 1; i < TOTSUBIMAGEM; i++)
            last_row = (tile_idx == TIW'(i)) ? band_last[i] : last_row;
    end

    conv_win_addr_gen #(.SIZE(SIZE), .SIZEKer(SIZEKer)) u_gen (
        .clock(clock),
        .nreset(nreset),
        .clr(abort),
        .en(img_rd_en),
        .last_row(last_row),
        .img_addr(img_rd_addr),
        .ker_addr(ker_rd_addr),
        .row(row),
        .col(col),
        .tap0(tap0),
        .last_tap(last_tap),
        .last_pix(last_pix)
    );

    assign img_rd_en = state == RUN;
    assign tile_done = state == TILE_WAIT;
    assign busy      = state == RUN || state == DRAIN || state == TILE_WAIT;
    assign last_band = tile_idx == TIW'(TOTSUBIMAGEM - 1);
    assign accept    = state == IDLE && start && !abort;
    assign ack_now   = state == TILE_WAIT && tile_ack;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = start ? RUN : IDLE;
            RUN:       nxt = last_pix ? DRAIN : RUN;
            DRAIN:     nxt = drain_cnt ? TILE_WAIT : DRAIN;
            TILE_WAIT: nxt = tile_ack ? (last_band ? DONE : RUN) : TILE_WAIT;
            DONE:      nxt = IDLE;
            default:   nxt = IDLE;
        endcase
        nxt = abort ? IDLE : nxt;
    end

    // Two-stage strobe pipeline matches the datapath's 1-cycle read latency
    always_ff @(posedge clock or posedge nreset)
        if (nreset) begin
            state <= IDLE;
            drain_cnt <= 1'b0;
            tile_idx <= '0;
            done <= 1'b0;
            mac_en <= 1'b0;
            mac_clr <= 1'b0;
            l1 <= 1'b0;
            wr_en <= 1'b0;
            row1 <= '0;
            col1 <= '0;
            out_row <= '0;
            out_col <= '0;
        end else begin
            state <= nxt;
            drain_cnt <= !abort && state == DRAIN && !drain_cnt;
            tile_idx <= (abort || accept) ? '0 : (ack_now && !last_band) ? tile_idx + 1'b1 : tile_idx;
            done <= (abort || accept) ? 1'b0 : (ack_now && last_band) ? 1'b1 : done;
            mac_en <= img_rd_en && !abort;
            mac_clr <= img_rd_en && tap0 && !abort;
            l1 <= img_rd_en && last_tap && !abort;
            wr_en <= l1 && !abort;
            row1 <= row;
            col1 <= col;
            out_row <= row1;
            out_col <= col1;
        end
endmodule

// File: tb/tb_conv_band_scheduler.sv
// tb_conv_band_scheduler: directed checks of tap order, band handshake, abort,
// async reset and full-frame coverage on three small configurations.
module tb_conv_band_scheduler;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    int nvec = 0, nmis = 0;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    // A: SIZE=8, K=3, T=2
    logic rst_a, start_a, abort_a, ack_a;
    logic a_busy, a_done, a_rd, a_mac, a_clr, a_wr, a_td;
    logic [5:0] a_addr;
    logic [3:0] a_ker;
    logic [2:0] a_row, a_col;
    logic [1:0] a_tidx;

    conv_band_scheduler #(.SIZE(8), .SIZEKer(3), .WIDTH_BIT(16), .TOTSUBIMAGEM(2)) dut_a (
        .clock(clock), .nreset(rst_a), .start(start_a), .abort(abort_a), .tile_ack(ack_a),
        .busy(a_busy), .done(a_done), .img_rd_en(a_rd), .img_rd_addr(a_addr), .ker_rd_addr(a_ker),
        .mac_en(a_mac), .mac_clr(a_clr), .wr_en(a_wr), .out_row(a_row), .out_col(a_col),
        .tile_done(a_td), .tile_idx(a_tidx)
    );

    // B: SIZE=8, K=3, T=4 and C: SIZE=16, K=3, T=5 share stimulus, ack held high
    logic rst_bc, start_bc, abort_bc, ack_bc;
    logic b_busy, b_done, b_rd, b_mac, b_clr, b_wr, b_td;
    logic [5:0] b_addr;
    logic [3:0] b_ker;
    logic [2:0] b_row, b_col;
    logic [2:0] b_tidx;
    logic c_busy, c_done, c_rd, c_mac, c_clr, c_wr, c_td;
    logic [7:0] c_addr;
    logic [3:0] c_ker;
    logic [3:0] c_row, c_col;
    logic [3:0] c_tidx;

    conv_band_scheduler #(.SIZE(8), .SIZEKer(3), .WIDTH_BIT(16), .TOTSUBIMAGEM(4)) dut_b (
        .clock(clock), .nreset(rst_bc), .start(start_bc), .abort(abort_bc), .tile_ack(ack_bc),
        .busy(b_busy), .done(b_done), .img_rd_en(b_rd), .img_rd_addr(b_addr), .ker_rd_addr(b_ker),
        .mac_en(b_mac), .mac_clr(b_clr), .wr_en(b_wr), .out_row(b_row), .out_col(b_col),
        .tile_done(b_td), .tile_idx(b_tidx)
    );

    conv_band_scheduler #(.SIZE(16), .SIZEKer(3), .WIDTH_BIT(16), .TOTSUBIMAGEM(5)) dut_c (
        .clock(clock), .nreset(rst_bc), .start(start_bc), .abort(abort_bc), .tile_ack(ack_bc),
        .busy(c_busy), .done(c_done), .img_rd_en(c_rd), .img_rd_addr(c_addr), .ker_rd_addr(c_ker),
        .mac_en(c_mac), .mac_clr(c_clr), .wr_en(c_wr), .out_row(c_row), .out_col(c_col),
        .tile_done(c_td), .tile_idx(c_tidx)
    );

    int exp1 [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int band_b_exp [4] = '{6, 12, 6, 12};
    int band_b [4];
    int seen [14][14];
    int nwr, cyc, last_wr;

    // Counts A's writes up to tile_done, checking raster order against nwr
    task automatic run_band_a;
        cyc = 0;
        while (!a_td && cyc < 400) begin
            if (a_wr) begin
                expect_eq("a_coord", {26'd0, a_row, a_col}, {26'd0, 3'(nwr / 6), 3'(nwr % 6)});
                nwr++;
                last_wr = cyc;
            end
            tick;
            cyc++;
        end
        expect_eq("a_band_timeout", a_td, 1);
    endtask

    initial begin
        int nwr_b, ntd_b, nwr_c, ntd_c, bad, lastb;
        rst_a = 1; start_a = 0; abort_a = 0; ack_a = 0;
        rst_bc = 1; start_bc = 0; abort_bc = 0; ack_bc = 1;
        repeat (2) tick;
        rst_a = 0; rst_bc = 0;
        tick;
        expect_eq("rst_strobes", {a_busy, a_done, a_rd, a_mac, a_clr, a_wr, a_td}, 0);
        expect_eq("rst_vals", {a_addr, a_ker, a_row, a_col, a_tidx}, 0);

        // first pixel taps, MAC controls and write latency
        start_a = 1;
        tick;
        start_a = 0;
        for (int k = 0; k <= 10; k++) begin
            if (k < 9) begin
                expect_eq("t1_addr", a_addr, exp1[k]);
                expect_eq("t1_ker", a_ker, k);
            end
            if (k == 1) expect_eq("t1_mac_clr", {a_mac, a_clr}, 2'b11);
            if (k == 2) expect_eq("t1_mac_acc", {a_mac, a_clr}, 2'b10);
            if (k == 9) expect_eq("t1_no_wr", a_wr, 0);
            if (k == 10) expect_eq("t1_wr00", {a_wr, a_row, a_col}, 7'b1_000_000);
            if (k < 10) tick;
        end

        // band 0 handshake with a slow writer
        nwr = 0;
        run_band_a;
        expect_eq("t2_band0_wr", nwr, 18);
        expect_eq("t2_tidx0", a_tidx, 0);
        expect_eq("t2_td_after_wr", cyc - last_wr, 1);
        for (int i = 0; i < 5; i++) begin
            expect_eq("t2_wait_idle", {a_rd, a_mac, a_wr, a_td, a_busy}, 5'b00011);
            tick;
        end
        ack_a = 1;
        tick;
        ack_a = 0;
        expect_eq("t2_band1_tap0", {a_rd, a_addr, a_ker}, {1'b1, 6'd24, 4'd0});
        run_band_a;
        expect_eq("t2_total_wr", nwr, 36);
        expect_eq("t2_tidx1", a_tidx, 1);
        ack_a = 1;
        tick;
        ack_a = 0;
        expect_eq("t2_done", {a_done, a_busy, a_td}, 3'b100);
        repeat (3) tick;
        expect_eq("t2_done_held", a_done, 1);

        // abort on the last tap of pixel 7: its write must never appear
        start_a = 1;
        tick;
        start_a = 0;
        expect_eq("t4_start_clears_done", {a_done, a_rd, a_addr}, {1'b0, 1'b1, 6'd0});
        repeat (62) tick;
        expect_eq("t4_pix7_last_addr", a_addr, 26);
        abort_a = 1;
        tick;
        abort_a = 0;
        expect_eq("t4_abort", {a_busy, a_rd, a_mac, a_wr, a_done}, 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            bad += (a_wr || a_busy) ? 1 : 0;
            tick;
        end
        expect_eq("t4_flushed", bad, 0);
        start_a = 1;
        tick;
        start_a = 0;
        expect_eq("t4_restart_addr", {a_rd, a_addr, a_ker}, {1'b1, 6'd0, 4'd0});
        repeat (10) tick;
        expect_eq("t4_restart_wr", {a_wr, a_row, a_col}, 7'b1_000_000);

        // async reset in the middle of DRAIN
        repeat (152) tick;
        expect_eq("t5_in_drain", {a_busy, a_rd, a_mac}, 3'b101);
        #2 rst_a = 1;
        #1;
        expect_eq("t5_async_zero", {a_busy, a_mac, a_wr, a_td, a_addr, a_row}, 0);
        tick;
        expect_eq("t5_no_wr", {a_wr, a_busy}, 0);
        rst_a = 0;
        tick;
        start_a = 1;
        tick;
        start_a = 0;
        expect_eq("t5_restart", {a_busy, a_rd, a_addr}, {1'b1, 1'b1, 6'd0});

        // full frames on B and C with writer always ready
        for (int r = 0; r < 14; r++)
            for (int c = 0; c < 14; c++) seen[r][c] = 0;
        for (int i = 0; i < 4; i++) band_b[i] = 0;
        nwr_b = 0; ntd_b = 0; nwr_c = 0; ntd_c = 0; lastb = 0;
        start_bc = 1;
        tick;
        start_bc = 0;
        expect_eq("t3_b_tap0", {b_busy, b_rd, b_addr, b_ker}, {2'b11, 6'd0, 4'd0});
        expect_eq("t6_c_tap0", {c_rd, c_addr, c_ker}, {1'b1, 8'd0, 4'd0});
        tick;
        expect_eq("t3_b_mac", {b_mac, b_clr}, 2'b11);
        expect_eq("t6_c_mac", {c_mac, c_clr}, 2'b11);
        cyc = 0;
        while (!(b_done && c_done) && cyc < 3000) begin
            if (b_wr) begin
                nwr_b++;
                if (ntd_b < 4) band_b[ntd_b]++;
                lastb = {b_row, b_col};
            end
            if (b_td) begin
                expect_eq("t3_b_tidx", b_tidx, ntd_b);
                ntd_b++;
            end
            if (c_wr) begin
                nwr_c++;
                if (c_row < 14 && c_col < 14) seen[c_row][c_col]++;
            end
            if (c_td) begin
                expect_eq("t6_c_tidx", c_tidx, ntd_c);
                ntd_c++;
            end
            tick;
            cyc++;
        end
        expect_eq("bc_timeout", b_done && c_done, 1);
        expect_eq("t3_tiles", ntd_b, 4);
        expect_eq("t3_wr", nwr_b, 36);
        expect_eq("t3_last_out", lastb, {3'd5, 3'd5});
        for (int i = 0; i < 4; i++) expect_eq("t3_band_height", band_b[i], band_b_exp[i]);
        expect_eq("t6_wr", nwr_c, 196);
        expect_eq("t6_tiles", ntd_c, 5);
        bad = 0;
        for (int r = 0; r < 14; r++)
            for (int c = 0; c < 14; c++) bad += (seen[r][c] != 1) ? 1 : 0;
        expect_eq("t6_each_once", bad, 0);
        repeat (10) tick;
        expect_eq("t6_done_held", {c_done, c_busy}, 2'b10);
        start_bc = 1;
        tick;
        start_bc = 0;
        expect_eq("t6_done_cleared", {c_done, c_busy}, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
